// File: rtl/arm_multicycle_ctrl.sv
// Multicycle ARM-subset control unit: step FSM, main/ALU decode, NZCV register, condition check.
// Latency: outputs are a Moore decode of the current state and IR; state and flags update each clk edge.
// Backpressure: none; the datapath executes one step per cycle and the FSM never stalls.
//
// Ports:
//   clk, reset        clock and asynchronous active-high reset
//   Instr[19:0]       IR[31:12] = {cond, op, funct, rn, rd}
//   ALUFlags[3:0]     {N,Z,C,V} produced by the ALU this cycle
//   PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
//   ALUSrcA, ALUSrcB, ImmSrc, RegWrite, RegSrc   datapath controls
//   Flags[3:0]        architectural NZCV
//   State[3:0]        current FSM state (debug)
module arm_multicycle_ctrl #(
  parameter logic [3:0] RESET_STATE  = 4'd0,
  parameter logic [2:0] MOV_ALU_CODE = 3'b101
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic [1:0]  ResultSrc,
  output logic [2:0]  ALUControl,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ImmSrc,
  output logic        RegWrite,
  output logic [1:0]  RegSrc,
  output logic [3:0]  Flags,
  output logic [3:0]  State
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_EOR = 3'b100;

  state_t state;
  logic [3:0] flags_q;

  // IR field views (Instr is IR[31:12])
  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       rd_is_pc;
  assign cond     = Instr[19:16];
  assign op       = Instr[15:14];
  assign funct    = Instr[13:8];
  assign rd       = Instr[3:0];
  assign rd_is_pc = (rd == 4'd15);

  // rn is consumed by the datapath only
  logic unused_rn;
  assign unused_rn = ^Instr[7:4];

  // Condition check against the architectural flags
  logic flag_n, flag_z, flag_c, flag_v, cond_ex;
  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = flag_z;
      4'b0001: cond_ex = !flag_z;
      4'b0010: cond_ex = flag_c;
      4'b0011: cond_ex = !flag_c;
      4'b0100: cond_ex = flag_n;
      4'b0101: cond_ex = !flag_n;
      4'b0110: cond_ex = flag_v;
      4'b0111: cond_ex = !flag_v;
      4'b1000: cond_ex = flag_c && !flag_z;
      4'b1001: cond_ex = !flag_c || flag_z;
      4'b1010: cond_ex = (flag_n == flag_v);
      4'b1011: cond_ex = (flag_n != flag_v);
      4'b1100: cond_ex = !flag_z && (flag_n == flag_v);
      4'b1101: cond_ex = flag_z || (flag_n != flag_v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // Data-processing decode from funct[4:1]
  logic [2:0] dp_alu;
  logic       dp_known;   // recognised opcode: may update N,Z
  logic       dp_write;   // result goes back to the register file
  logic       dp_cv;      // arithmetic op: may update C,V

  always_comb begin
    dp_alu   = ALU_ADD;
    dp_known = 1'b1;
    dp_write = 1'b1;
    dp_cv    = 1'b0;
    case (funct[4:1])
      4'b0100: begin dp_alu = ALU_ADD; dp_cv = 1'b1; end
      4'b0010: begin dp_alu = ALU_SUB; dp_cv = 1'b1; end
      4'b0000: dp_alu = ALU_AND;
      4'b1100: dp_alu = ALU_ORR;
      4'b0001: dp_alu = ALU_EOR;
      4'b1101: dp_alu = MOV_ALU_CODE;
      4'b1010: begin dp_alu = ALU_SUB; dp_write = 1'b0; dp_cv = 1'b1; end
      4'b1000: begin dp_alu = ALU_AND; dp_write = 1'b0; end
      default: begin dp_known = 1'b0; dp_write = 1'b0; end
    endcase
  end

  // Step FSM and flag register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= state_t'(RESET_STATE);
      flags_q <= 4'b0000;
    end else begin
      case (state)
        S_FETCH:  state <= S_DECODE;
        S_DECODE: begin
          if (!cond_ex) begin
            state <= S_FETCH;
          end else begin
            case (op)
              2'b01:   state <= S_MEMADR;
              2'b00:   state <= funct[5] ? S_EXECI : S_EXECR;
              2'b10:   state <= S_BRANCH;
              default: state <= S_FETCH;
            endcase
          end
        end
        S_MEMADR: state <= funct[0] ? S_MEMRD : S_MEMWR;
        S_MEMRD:  state <= S_MEMWB;
        S_EXECR, S_EXECI: begin
          // S bit: the flags produced by this execute step become architectural
          if (funct[0] && dp_known) begin
            flags_q[3:2] <= ALUFlags[3:2];
            if (dp_cv) flags_q[1:0] <= ALUFlags[1:0];
          end
          state <= dp_write ? S_ALUWB : S_FETCH;
        end
        default:  state <= S_FETCH;
      endcase
    end
  end

  // Moore output decode
  always_comb begin
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    ResultSrc  = 2'b00;
    ALUControl = ALU_ADD;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ImmSrc     = 2'b00;
    RegWrite   = 1'b0;
    RegSrc     = 2'b00;

    // In FETCH the IR still holds the previous instruction, so these stay 0 there
    if (state != S_FETCH) begin
      case (op)
        2'b01:   begin RegSrc = 2'b10; ImmSrc = 2'b01; end
        2'b10:   begin RegSrc = 2'b01; ImmSrc = 2'b10; end
        default: begin RegSrc = 2'b00; ImmSrc = 2'b00; end
      endcase
    end

    case (state)
      S_FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        PCWrite   = 1'b1;
      end
      S_DECODE: begin
        // PC+4 again so the register file sees R15 = PC+8
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_MEMADR: ALUSrcB = 2'b01;
      S_MEMRD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        PCWrite   = rd_is_pc;
      end
      S_MEMWR: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECR:  ALUControl = dp_alu;
      S_EXECI: begin
        ALUSrcB    = 2'b01;
        ALUControl = dp_alu;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        PCWrite  = rd_is_pc;
      end
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCWrite   = 1'b1;
      end
      default: ;
    endcase

    // Reset holds FETCH, whose enables would otherwise be live
    if (reset) begin
      PCWrite  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
    end
  end

  assign Flags = flags_q;
  assign State = state;

endmodule
